curl_pow_sequencer: RTL

Job sequencer that sits directly upstream of the Curl PoW core. It takes a transaction as a stream of 54-bit words, each word holding 27 trits at 2 bits per trit. It writes the words into the core 9 at a time (243 trits per chunk) and pulses transform for every absorb chunk. After the last absorb chunk it writes the final chunk and starts PoW with a mask derived from the minimum weight magnitude (MWM). It then counts hash attempts and captures the winning nonce.

---
 rtl/curl_pow_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/curl_pow_sequencer.sv
// Job sequencer in front of the Curl PoW core: loads 9-word chunks, issues absorb
// transforms, then launches PoW with an MWM mask and captures the winning nonce.
module curl_pow_sequencer #(
    parameter int DATA_WIDTH  = 54,
    parameter int ADDR_WIDTH  = 4,
    parameter int CNT_WIDTH   = 6,
    parameter int NONCE_WIDTH = 162
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   i_start,
    input  logic [CNT_WIDTH-1:0]   i_block_cnt,
    input  logic [5:0]             i_mwm,
    input  logic                   i_word_valid,
    input  logic [DATA_WIDTH-1:0]  i_word,
    output logic                   o_word_ready,
    output logic                   o_core_we,
    output logic [ADDR_WIDTH-1:0]  o_core_addr,
    output logic [DATA_WIDTH-1:0]  o_core_data,
    output logic                   o_core_transform,
    output logic                   o_core_pow,
    output logic [31:0]            o_core_mwm_mask,
    input  logic                   i_core_transforming,
    input  logic                   i_core_pow_hash_finish,
    input  logic                   i_core_pow_finish,
    input  logic [NONCE_WIDTH-1:0] i_core_nonce,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic [NONCE_WIDTH-1:0] o_nonce,
    output logic [31:0]            o_hash_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_XF_REQ, S_XF_ARM, S_XF_WAIT, S_POW_REQ, S_POW_WAIT, S_POW_CHK
    } state_t;

    // Word stream handshake: a word moves on a rising edge where i_word_valid and o_word_ready are both 1.
    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_chunks_left;
    logic [ADDR_WIDTH-1:0]  r_word_idx;
    logic                   r_core_we;
    logic [ADDR_WIDTH-1:0]  r_core_addr;
    logic [DATA_WIDTH-1:0]  r_core_data;
    logic                   r_core_transform;
    logic                   r_core_pow;
    logic [31:0]            r_mask;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [NONCE_WIDTH-1:0] r_nonce;
    logic [31:0]            r_hash_cnt;

    logic [31:0] w_mask;
    logic        w_last_word;

    assign w_mask      = (i_mwm >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << i_mwm) - 32'd1);
    assign w_last_word = (r_word_idx == ADDR_WIDTH'(8));

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state          <= S_IDLE;
            r_chunks_left    <= '0;
            r_word_idx       <= '0;
            r_core_we        <= 1'b0;
            r_core_addr      <= '0;
            r_core_data      <= '0;
            r_core_transform <= 1'b0;
            r_core_pow       <= 1'b0;
            r_mask           <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err            <= 1'b0;
            r_nonce          <= '0;
            r_hash_cnt       <= '0;
        end else begin
            r_core_we        <= 1'b0;
            r_core_transform <= 1'b0;
            r_core_pow       <= 1'b0;
            r_done           <= 1'b0;
            r_err            <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_block_cnt == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_chunks_left <= i_block_cnt;
                            r_mask        <= w_mask;
                            r_hash_cnt    <= '0;
                            r_word_idx    <= '0;
                            r_busy        <= 1'b1;
                            r_state       <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_word_valid) begin
                        r_core_we   <= 1'b1;
                        r_core_addr <= r_word_idx;
                        r_core_data <= i_word;
                        if (w_last_word) begin
                            r_word_idx <= '0;
                            r_state    <= (r_chunks_left != '0) ? S_XF_REQ : S_POW_REQ;
                        end else begin
                            r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_XF_REQ: begin
                    r_core_transform <= 1'b1;
                    r_chunks_left    <= r_chunks_left - CNT_WIDTH'(1);
                    r_state          <= S_XF_ARM;
                end
                // The core's busy flag only rises one edge after it sees the transform pulse.
                S_XF_ARM: r_state <= S_XF_WAIT;
                S_XF_WAIT: begin
                    if (!i_core_transforming) r_state <= S_LOAD;
                end
                S_POW_REQ: begin
                    r_core_pow <= 1'b1;
                    r_state    <= S_POW_WAIT;
                end
                S_POW_WAIT: begin
                    if (i_core_pow_hash_finish) begin
                        if (r_hash_cnt != 32'hFFFF_FFFF) r_hash_cnt <= r_hash_cnt + 32'd1;
                        r_state <= S_POW_CHK;
                    end
                end
                S_POW_CHK: begin
                    if (i_core_pow_finish) begin
                        r_nonce <= i_core_nonce;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_POW_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Ready is decoded from state so an asynchronous reset drops it immediately.
    assign o_word_ready     = (r_state == S_LOAD);
    assign o_core_we        = r_core_we;
    assign o_core_addr      = r_core_addr;
    assign o_core_data      = r_core_data;
    assign o_core_transform = r_core_transform;
    assign o_core_pow       = r_core_pow;
    assign o_core_mwm_mask  = r_mask;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_err            = r_err;
    assign o_nonce          = r_nonce;
    assign o_hash_cnt       = r_hash_cnt;

endmodule
